// File: rtl/student_pc_n.sv
// -----------------------------------------------------------------------------
// student_pc_n -- parametrised program-counter / loop-counter register.
//
// A WIDTH-bit state register. On each rising clock edge it does exactly one
// of: synchronous clear, load, bitwise AND-mask, increment by STEP, decrement
// by STEP, or hold. Clear has the highest priority and hold the lowest.
// `wrap` is a registered flag. It goes high for one cycle after an inc or dec
// that crossed the modulus 2^WIDTH.
//
// The AND-mask datapath is built from one student_and gate per bit.
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-high reset (out=RESET_VALUE, wrap=0)
//   clr    in   1      synchronous clear to zero
//   load   in   1      synchronous load of `in`
//   mask   in   1      synchronous out <= out AND in
//   inc    in   1      add STEP (only when dec=0)
//   dec    in   1      subtract STEP (only when inc=0)
//   in     in   WIDTH  load / mask operand, sampled at the edge
//   out    out  WIDTH  current register value (pure flop output)
//   wrap   out  1      carry/borrow of the last inc/dec (pure flop output)
// -----------------------------------------------------------------------------

// Single-bit AND gate, the leaf cell of the mask datapath.
//   a, b  in   1  operands
//   y     out  1  a AND b
module student_and (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module student_pc_n #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] STEP        = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             mask,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLR,
    ACT_LOAD,
    ACT_MASK,
    ACT_INC,
    ACT_DEC
  } action_t;

  // STEP widened by one bit, so the carry/borrow lands in bit WIDTH.
  localparam logic [WIDTH:0] STEP_EXT = {1'b0, STEP};

  action_t          action;
  logic [WIDTH-1:0] masked;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] out_next;
  logic             wrap_next;

  // Per-bit mask gates: out AND in.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mask
    student_and u_and (
      .a (out[i]),
      .b (in[i]),
      .y (masked[i])
    );
  end

  // Bit WIDTH of sum is the carry out. Bit WIDTH of diff is the borrow,
  // which is set exactly when out < STEP.
  assign sum  = {1'b0, out} + STEP_EXT;
  assign diff = {1'b0, out} - STEP_EXT;

  // Priority decode. inc and dec together fall through to hold.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    action = ACT_HOLD;
    if (clr)              action = ACT_CLR;
    else if (load)        action = ACT_LOAD;
    else if (mask)        action = ACT_MASK;
    else if (inc && !dec) action = ACT_INC;
    else if (dec && !inc) action = ACT_DEC;
  end

  // Next-state datapath. wrap defaults to 0, so any edge that is not a
  // wrapping inc/dec clears it, including edges where clr/load/mask win.
  always_comb begin
    out_next  = out;
    wrap_next = 1'b0;
    unique case (action)
      ACT_CLR:  out_next = '0;
      ACT_LOAD: out_next = in;
      ACT_MASK: out_next = masked;
      ACT_INC: begin
        out_next  = sum[WIDTH-1:0];
        wrap_next = sum[WIDTH];
      end
      ACT_DEC: begin
        out_next  = diff[WIDTH-1:0];
        wrap_next = diff[WIDTH];
      end
      default: out_next = out;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out  <= RESET_VALUE;
      wrap <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples values from before the edge.
      out  <= out_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_student_pc_n.sv
// -----------------------------------------------------------------------------
// tb_student_pc_n -- self-checking bench for student_pc_n.
//
// Two instances share clock, reset and controls:
//   dut16: WIDTH=16, RESET_VALUE=0x0100, STEP=1
//   dut8 : WIDTH=8,  RESET_VALUE=0x00,   STEP=3 (its operand is in16[7:0])
// The bench applies a table of directed vectors, then hand-written reset
// sequences, then a mask sweep and a random run. The random run is compared
// against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_student_pc_n;

  localparam logic [15:0] RV16 = 16'h0100;
  localparam logic [7:0]  RV8  = 8'h00;

  logic        clk;
  logic        reset;
  logic        clr, load, mask, inc, dec;
  logic [15:0] in16;
  logic [7:0]  in8;
  logic [15:0] out16;
  logic [7:0]  out8;
  logic        wrap16, wrap8;

  assign in8 = in16[7:0];

  student_pc_n #(.WIDTH(16), .RESET_VALUE(RV16), .STEP(16'd1)) dut16 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .mask(mask),
    .inc(inc), .dec(dec), .in(in16), .out(out16), .wrap(wrap16)
  );

  student_pc_n #(.WIDTH(8), .RESET_VALUE(RV8), .STEP(8'd3)) dut8 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .mask(mask),
    .inc(inc), .dec(dec), .in(in8), .out(out8), .wrap(wrap8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint val;
    bit     wr;
  } res_t;

  function automatic res_t ref_step(input int w, input longint stp, input longint cur,
                                    input bit c, input bit l, input bit mk,
                                    input bit i, input bit d, input longint inv);
    longint modv;
    res_t   r;
    modv = longint'(1) << w;
    r.val = cur;
    r.wr  = 1'b0;
    if (c)           r.val = 0;
    else if (l)      r.val = inv % modv;
    else if (mk)     r.val = cur & (inv % modv);
    else if (i && !d) begin
      r.wr  = (cur + stp) >= modv;
      r.val = (cur + stp) % modv;
    end else if (d && !i) begin
      r.wr  = cur < stp;
      r.val = (cur + modv - stp) % modv;
    end
    return r;
  endfunction

  longint m16, m8;
  bit     w16, w8;

  task automatic model_reset();
    m16 = longint'(RV16);
    m8  = longint'(RV8);
    w16 = 1'b0;
    w8  = 1'b0;
  endtask

  // Drive one action, advance one edge and update the model. The task
  // returns 1 time unit after the edge, where outputs are sampled.
  task automatic drive(input bit c, input bit l, input bit mk, input bit i,
                       input bit d, input logic [15:0] v);
    res_t r;
    clr = c; load = l; mask = mk; inc = i; dec = d; in16 = v;
    r = ref_step(16, 1, m16, c, l, mk, i, d, longint'(v));
    m16 = r.val; w16 = r.wr;
    r = ref_step(8, 3, m8, c, l, mk, i, d, longint'(v));
    m8 = r.val; w8 = r.wr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_out16"},  32'(out16),  32'(m16));
    check({tag, "_wrap16"}, 32'(wrap16), 32'(w16));
    check({tag, "_out8"},   32'(out8),   32'(m8));
    check({tag, "_wrap8"},  32'(wrap8),  32'(w8));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          c, l, mk, i, d;
    logic [15:0] v;
    logic [15:0] e16;
    bit          ew16;
    logic [7:0]  e8;
    bit          ew8;
  } vec_t;

  function automatic vec_t mkv(input bit c, input bit l, input bit mk, input bit i,
                               input bit d, input logic [15:0] v,
                               input logic [15:0] e16, input bit ew16,
                               input logic [7:0] e8, input bit ew8);
    vec_t t;
    t.c = c; t.l = l; t.mk = mk; t.i = i; t.d = d; t.v = v;
    t.e16 = e16; t.ew16 = ew16; t.e8 = e8; t.ew8 = ew8;
    return t;
  endfunction

  vec_t tbl[18];

  initial begin
    // Expected values are worked out by hand from the operation rules.
    //            clr ld mk inc dec  in        out16    w  out8   w
    tbl[0]  = mkv(0, 0, 0, 1, 0, 16'h0000, 16'h0101, 0, 8'h03, 0);
    tbl[1]  = mkv(0, 0, 0, 1, 0, 16'h0000, 16'h0102, 0, 8'h06, 0);
    tbl[2]  = mkv(0, 0, 0, 1, 0, 16'h0000, 16'h0103, 0, 8'h09, 0);
    tbl[3]  = mkv(1, 1, 0, 0, 0, 16'hBEEF, 16'h0000, 0, 8'h00, 0);
    tbl[4]  = mkv(0, 1, 1, 1, 0, 16'h1234, 16'h1234, 0, 8'h34, 0);
    tbl[5]  = mkv(0, 1, 0, 0, 0, 16'hF0F0, 16'hF0F0, 0, 8'hF0, 0);
    tbl[6]  = mkv(0, 0, 1, 0, 0, 16'h3C3C, 16'h3030, 0, 8'h30, 0);
    tbl[7]  = mkv(0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 8'hFF, 0);
    tbl[8]  = mkv(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 8'h02, 1);
    tbl[9]  = mkv(0, 0, 0, 1, 0, 16'h0000, 16'h0001, 0, 8'h05, 0);
    tbl[10] = mkv(0, 1, 0, 0, 0, 16'h0001, 16'h0001, 0, 8'h01, 0);
    tbl[11] = mkv(0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 8'hFE, 1);
    tbl[12] = mkv(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 8'hFE, 0);
    tbl[13] = mkv(0, 0, 0, 0, 1, 16'h0000, 16'hFFFF, 1, 8'hFB, 0);
    tbl[14] = mkv(0, 0, 0, 0, 1, 16'h0000, 16'hFFFE, 0, 8'hF8, 0);
    tbl[15] = mkv(0, 1, 0, 0, 0, 16'h00FE, 16'h00FE, 0, 8'hFE, 0);
    tbl[16] = mkv(0, 0, 0, 1, 0, 16'h0000, 16'h00FF, 0, 8'h01, 1);
    tbl[17] = mkv(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 8'h00, 0);

    clr = 0; load = 0; mask = 0; inc = 0; dec = 0; in16 = '0;
    reset = 1'b1;
    model_reset();

    // Reset is asynchronous, so outputs are defined before any clock edge.
    #3;
    check("rst_async_out16",  32'(out16),  32'(RV16));
    check("rst_async_wrap16", 32'(wrap16), 32'd0);
    check("rst_async_out8",   32'(out8),   32'(RV8));

    @(posedge clk);
    #1;
    reset = 1'b0;

    // ---- table ----
    for (int k = 0; k < 18; k++) begin
      drive(tbl[k].c, tbl[k].l, tbl[k].mk, tbl[k].i, tbl[k].d, tbl[k].v);
      check($sformatf("tbl%0d_out16", k),  32'(out16),  32'(tbl[k].e16));
      check($sformatf("tbl%0d_wrap16", k), 32'(wrap16), 32'(tbl[k].ew16));
      check($sformatf("tbl%0d_out8", k),   32'(out8),   32'(tbl[k].e8));
      check($sformatf("tbl%0d_wrap8", k),  32'(wrap8),  32'(tbl[k].ew8));
    end

    // ---- reset asserted between edges during an inc run ----
    for (int k = 0; k < 7; k++) drive(0, 0, 0, 1, 0, 16'h0000);
    check("count_out16", 32'(out16), 32'h0007);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out16", 32'(out16), 32'(RV16));
    check("midrst_out8",  32'(out8),  32'(RV8));
    // inc stays high across an edge while reset is held, and must be ignored.
    @(posedge clk);
    #1;
    check("rst_hold_out16", 32'(out16), 32'(RV16));
    reset = 1'b0;
    model_reset();
    drive(0, 0, 0, 1, 0, 16'h0000);
    check("resume_out16",  32'(out16),  32'h0101);
    check("resume_wrap16", 32'(wrap16), 32'd0);

    // ---- reset asserted while wrap is high ----
    drive(0, 1, 0, 0, 0, 16'hFFFF);
    drive(0, 0, 0, 1, 0, 16'h0000);
    check("prewrap_wrap16", 32'(wrap16), 32'd1);
    check("prewrap_wrap8",  32'(wrap8),  32'd1);
    inc = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rstwrap_wrap16", 32'(wrap16), 32'd0);
    check("rstwrap_wrap8",  32'(wrap8),  32'd0);
    check("rstwrap_out16",  32'(out16),  32'(RV16));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    drive(0, 0, 0, 1, 0, 16'h0000);
    check("nostale_wrap16", 32'(wrap16), 32'd0);
    check("nostale_out16",  32'(out16),  32'h0101);

    // ---- mask sweep: 200 random operand pairs ----
    for (int k = 0; k < 200; k++) begin
      logic [15:0] a, b, e;
      a = 16'($urandom);
      b = 16'($urandom);
      e = a & b;
      drive(0, 1, 0, 0, 0, a);
      drive(0, 0, 1, 0, 0, b);
      check("mask_sweep16", 32'(out16), 32'(e));
      check("mask_sweep8",  32'(out8),  32'(e[7:0]));
    end

    // ---- random actions against the reference model ----
    // clr/load/mask are kept rare, so runs of inc/dec cross the modulus.
    for (int k = 0; k < 400; k++) begin
      bit c, l, mk, i, d;
      logic [15:0] v;
      c  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 9) == 0);
      mk = ($urandom_range(0, 9) == 0);
      i  = ($urandom_range(0, 1) == 1);
      d  = ($urandom_range(0, 2) == 0);
      v  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'hFFF0 | 16'($urandom_range(0, 15));
      drive(c, l, mk, i, d, v);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
